// File: rtl/usb_pkt_router.sv
// usb_pkt_router
// Packet cache and channel router between the USB3 read stream and the
// per-channel sample RAMs. A header word names a destination channel and a
// payload length; the following payload words are tagged with that channel,
// buffered in a FIFO and drained one per cycle with a one-hot write enable.
//
// Ports:
//   clock       rising-edge clock for all logic
//   rst         asynchronous active-high reset
//   in_valid    stream word present
//   in_ready    router accepts a word (transfer = in_valid & in_ready)
//   in_data     stream word
//   out_ready   downstream RAMs may take a word this cycle
//   out_data    routed payload word (registered, holds when idle)
//   out_wren    one-hot channel write enable, valid with out_data
//   fill_level  current FIFO occupancy
//   err_badch   one-cycle pulse: header named a channel >= NUM_CH
//   err_sync    one-cycle pulse: non-header word while hunting for a header
//   drop_cnt    saturating count of discarded stream words
//
// Parser states:
//   state   | meaning
//   HUNT    | waiting for a header word
//   PAYLOAD | storing payload words for the latched channel
//   DISCARD | swallowing payload of a header with an invalid channel
module usb_pkt_router #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter int                NUM_CH    = 24,
    parameter logic [DATA_W-1:0] HDR_MASK  = DATA_W'(32'hFF0000FF),
    parameter logic [DATA_W-1:0] HDR_MAGIC = DATA_W'(32'hFF0000FF)
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [NUM_CH-1:0]        out_wren,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     err_badch,
    output logic                     err_sync,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int EW = CW + DATA_W;
    localparam logic [AW:0]       FULL     = (AW+1)'(DEPTH);
    localparam logic [8:0]        CH_LIMIT = 9'(NUM_CH);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [7:0]     remaining;
    logic [CW-1:0]  tag;

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [EW-1:0]  mem [DEPTH];
    logic [EW-1:0]  rd_word;

    logic           xfer;
    logic           is_hdr;
    logic [7:0]     hdr_ch;
    logic [7:0]     hdr_len;
    logic           ch_ok;

    logic           push;
    logic           pop;
    logic           load_len;
    logic           dec_len;
    logic           badch_set;
    logic           sync_set;
    logic           drop_inc;

    // Ready comes only from the registered count, so a push is never
    // attempted into a full FIFO even when a pop happens the same cycle.
    assign in_ready   = ~rst & (count != FULL);
    assign xfer       = in_valid & in_ready;
    assign is_hdr     = (in_data & HDR_MASK) == HDR_MAGIC;
    assign hdr_ch     = in_data[23:16];
    assign hdr_len    = in_data[15:8];
    assign ch_ok      = {1'b0, hdr_ch} < CH_LIMIT;
    assign pop        = (count != '0) & out_ready;
    assign fill_level = count;

    // State register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (xfer) begin
            case (state)
                HUNT: begin
                    if (is_hdr) begin
                        state_nx = ch_ok ? PAYLOAD : DISCARD;
                    end
                end
                PAYLOAD, DISCARD: begin
                    if (remaining == 8'd0) begin
                        state_nx = HUNT;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        push      = 1'b0;
        load_len  = 1'b0;
        dec_len   = 1'b0;
        badch_set = 1'b0;
        sync_set  = 1'b0;
        drop_inc  = 1'b0;
        if (xfer) begin
            case (state)
                HUNT: begin
                    if (is_hdr) begin
                        load_len  = 1'b1;
                        badch_set = ~ch_ok;
                    end else begin
                        sync_set = 1'b1;
                        drop_inc = 1'b1;
                    end
                end
                PAYLOAD: begin
                    push    = 1'b1;
                    dec_len = 1'b1;
                end
                DISCARD: begin
                    drop_inc = 1'b1;
                    dec_len  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Packet bookkeeping, error pulses and drop counter
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            tag       <= '0;
            err_badch <= 1'b0;
            err_sync  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (load_len) begin
                remaining <= hdr_len;
            end else if (dec_len) begin
                remaining <= remaining - 8'd1;
            end
            if (load_len && ch_ok) begin
                tag <= hdr_ch[CW-1:0];
            end
            err_badch <= badch_set;
            err_sync  <= sync_set;
            if (drop_inc && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // FIFO storage: no reset needed, occupancy is tracked by count
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {tag, in_data};
        end
    end

    assign rd_word = mem[rd_ptr];

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered output stage: one cycle after a pop
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_wren <= '0;
        end else begin
            if (pop) begin
                out_data <= rd_word[DATA_W-1:0];
                out_wren <= ONE_HOT0 << rd_word[EW-1:DATA_W];
            end else begin
                out_wren <= '0;
            end
        end
    end

endmodule

// File: tb/tb_usb_pkt_router.sv
module tb_usb_pkt_router;

    logic        clock = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_ready;
    logic [31:0] out_data;
    logic [23:0] out_wren;
    logic [4:0]  fill_level;
    logic        err_badch;
    logic        err_sync;
    logic [15:0] drop_cnt;

    int n_total = 0;
    int n_pass  = 0;

    usb_pkt_router #(
        .DATA_W (32),
        .DEPTH  (16),
        .NUM_CH (24)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_wren   (out_wren),
        .fill_level (fill_level),
        .err_badch  (err_badch),
        .err_sync   (err_sync),
        .drop_cnt   (drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        vld;
        logic [31:0] din;
        logic [23:0] wren;
        logic [31:0] dout;
        logic [4:0]  fill;
        logic        badch;
        logic        sync;
        logic [15:0] drop;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    localparam logic [31:0] WA = 32'h1111_0001;
    localparam logic [31:0] WB = 32'h2222_0002;
    localparam logic [31:0] WC = 32'hFF00_00FF;
    localparam logic [31:0] WD = 32'h4444_0004;
    localparam logic [31:0] WE = 32'h5555_0005;
    localparam logic [31:0] WF = 32'h6666_0006;

    initial begin
        int k;
        int rx;
        logic acc;

        // ch | len : 5|3, 30|1 (bad), 23|0, 24|0 (bad), 5|0
        vecs[0]  = '{1, 32'hFF0503FF, 24'h000000, 32'h0,  5'd0, 0, 0, 16'd0};
        vecs[1]  = '{1, WA,           24'h000000, 32'h0,  5'd1, 0, 0, 16'd0};
        vecs[2]  = '{1, WB,           24'h000020, WA,     5'd1, 0, 0, 16'd0};
        vecs[3]  = '{1, WC,           24'h000020, WB,     5'd1, 0, 0, 16'd0};
        vecs[4]  = '{1, WD,           24'h000020, WC,     5'd1, 0, 0, 16'd0};
        vecs[5]  = '{0, 32'h0,        24'h000020, WD,     5'd0, 0, 0, 16'd0};
        vecs[6]  = '{0, 32'h0,        24'h000000, WD,     5'd0, 0, 0, 16'd0};
        vecs[7]  = '{1, 32'hFF1E01FF, 24'h000000, WD,     5'd0, 1, 0, 16'd0};
        vecs[8]  = '{1, 32'h0BAD_0001, 24'h000000, WD,    5'd0, 0, 0, 16'd1};
        vecs[9]  = '{1, 32'h0BAD_0002, 24'h000000, WD,    5'd0, 0, 0, 16'd2};
        vecs[10] = '{0, 32'h0,        24'h000000, WD,     5'd0, 0, 0, 16'd2};
        vecs[11] = '{1, 32'h1234_5678, 24'h000000, WD,    5'd0, 0, 1, 16'd3};
        vecs[12] = '{1, 32'h1234_5679, 24'h000000, WD,    5'd0, 0, 1, 16'd4};
        vecs[13] = '{1, 32'h1234_567A, 24'h000000, WD,    5'd0, 0, 1, 16'd5};
        vecs[14] = '{0, 32'h0,        24'h000000, WD,     5'd0, 0, 0, 16'd5};
        vecs[15] = '{1, 32'hFF1700FF, 24'h000000, WD,     5'd0, 0, 0, 16'd5};
        vecs[16] = '{1, WE,           24'h000000, WD,     5'd1, 0, 0, 16'd5};
        vecs[17] = '{0, 32'h0,        24'h800000, WE,     5'd0, 0, 0, 16'd5};
        vecs[18] = '{0, 32'h0,        24'h000000, WE,     5'd0, 0, 0, 16'd5};
        vecs[19] = '{1, 32'hFF1800FF, 24'h000000, WE,     5'd0, 1, 0, 16'd5};
        vecs[20] = '{1, 32'h0BAD_0003, 24'h000000, WE,    5'd0, 0, 0, 16'd6};
        vecs[21] = '{1, 32'hFF0500FF, 24'h000000, WE,     5'd0, 0, 0, 16'd6};
        vecs[22] = '{1, WF,           24'h000000, WE,     5'd1, 0, 0, 16'd6};
        vecs[23] = '{0, 32'h0,        24'h000020, WF,     5'd0, 0, 0, 16'd6};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_fill",     32'(fill_level), 32'd0);
        chk("rst_wren",     32'(out_wren), 32'd0);
        chk("rst_data",     out_data, 32'd0);
        chk("rst_drop",     32'(drop_cnt), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Table-driven vectors: inputs before the edge, outputs after it.
        for (int i = 0; i < 24; i++) begin
            in_valid = vecs[i].vld;
            in_data  = vecs[i].din;
            step();
            chk($sformatf("v%0d_wren", i),  32'(out_wren),   32'(vecs[i].wren));
            chk($sformatf("v%0d_data", i),  out_data,        vecs[i].dout);
            chk($sformatf("v%0d_fill", i),  32'(fill_level), 32'(vecs[i].fill));
            chk($sformatf("v%0d_badch", i), 32'(err_badch),  32'(vecs[i].badch));
            chk($sformatf("v%0d_sync", i),  32'(err_sync),   32'(vecs[i].sync));
            chk($sformatf("v%0d_drop", i),  32'(drop_cnt),   32'(vecs[i].drop));
        end
        in_valid = 1'b0;

        // Back-pressure: 20-word packet into a 16-deep FIFO, then drain.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hFF0213FF;
        step();
        k = 0;
        for (int c = 0; c < 25; c++) begin
            if (k < 20) begin
                in_valid = 1'b1;
                in_data  = 32'hA000_0000 + 32'(k);
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid & in_ready;
            step();
            if (acc) k++;
        end
        chk("full_accepted", 32'(k), 32'd16);
        chk("full_fill",     32'(fill_level), 32'd16);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_no_out",   32'(out_wren), 32'd0);

        out_ready = 1'b1;
        rx = 0;
        for (int c = 0; c < 100 && rx < 20; c++) begin
            if (k < 20) begin
                in_valid = 1'b1;
                in_data  = 32'hA000_0000 + 32'(k);
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid & in_ready;
            step();
            if (acc) k++;
            if (out_wren != '0) begin
                chk($sformatf("drain%0d_wren", rx), 32'(out_wren), 32'h0000_0004);
                chk($sformatf("drain%0d_data", rx), out_data, 32'hA000_0000 + 32'(rx));
                rx++;
            end
        end
        in_valid = 1'b0;
        chk("drain_count", 32'(rx), 32'd20);
        step();
        chk("drain_fill", 32'(fill_level), 32'd0);
        chk("drain_idle", 32'(out_wren), 32'd0);

        // Stray words then an asynchronous reset in the middle of a packet.
        do_reset();
        for (int s = 0; s < 3; s++) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_1000 + 32'(s);
            step();
            chk($sformatf("stray%0d_sync", s), 32'(err_sync), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stray_sync_low", 32'(err_sync), 32'd0);
        chk("stray_drop",     32'(drop_cnt), 32'd3);

        in_valid = 1'b1;
        in_data  = 32'hFF0505FF;
        step();
        in_data  = WA;
        step();
        in_data  = WB;
        step();
        in_valid = 1'b0;
        chk("mid_pre_wren", 32'(out_wren), 32'h0000_0020);
        chk("mid_pre_data", out_data, WA);
        #2;
        rst = 1'b1;
        #1;
        chk("async_wren",     32'(out_wren), 32'd0);
        chk("async_data",     out_data, 32'd0);
        chk("async_fill",     32'(fill_level), 32'd0);
        chk("async_drop",     32'(drop_cnt), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid = 1'b1;
            in_data  = 32'h3333_0000 + 32'(s);
            step();
            chk($sformatf("resid%0d_sync", s), 32'(err_sync), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("resid_drop", 32'(drop_cnt), 32'd2);
        chk("resid_fill", 32'(fill_level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
